// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with stall (pass/hold/bubble),
// flush, and optional saturating performance counters.
// Optional feature macro: PIPE_STAGE_PERF_EN builds the bubble/hold/flush
// counters and the illegal-stall-vector assertion. Without it the counters
// read 0 and perf_clr is ignored.
module pipe_stage_reg #(
    parameter int              DATA_W    = 64,
    parameter int              STALL_W   = 6,
    parameter int              STAGE     = 1,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0,
    parameter int              CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               perf_clr,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   hold_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    // The downstream stall bit must exist in the vector.
    generate
        if (STAGE < 0 || STAGE + 1 >= STALL_W) begin : g_bad_stage
            $fatal(1, "pipe_stage_reg: STAGE+1 must be < STALL_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        ACT_PASS   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_BUBBLE = 2'd2,
        ACT_FLUSH  = 2'd3
    } act_e;

    logic up_stall;
    logic dn_stall;
    act_e act;

    assign up_stall = stall[STAGE];
    assign dn_stall = stall[STAGE+1];

    // Only two stall bits matter here; perf_clr is unused in the default build.
    logic unused_bits;
    assign unused_bits = ^{stall, perf_clr};

    // Per-edge action; flush wins over stall, and an illegal vector
    // (upstream running, downstream stalled) falls through to PASS.
    always_comb begin
        act = ACT_PASS;
        if (flush)
            act = ACT_FLUSH;
        else if (up_stall && !dn_stall)
            act = ACT_BUBBLE;
        else if (up_stall)
            act = ACT_HOLD;
    end

    // Payload/valid register: bubble and flush always load NOP, never in_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= NOP_VALUE;
            out_valid <= 1'b0;
        end else begin
            case (act)
                ACT_PASS: begin
                    out_data  <= in_data;
                    out_valid <= in_valid;
                end
                ACT_HOLD: begin
                    out_data  <= out_data;
                    out_valid <= out_valid;
                end
                default: begin
                    out_data  <= NOP_VALUE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    // Saturating event counters; rst beats perf_clr, perf_clr beats increments.
    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            bubble_cnt <= '0;
            hold_cnt   <= '0;
            flush_cnt  <= '0;
        end else begin
            if (act == ACT_BUBBLE) bubble_cnt <= sat_inc(bubble_cnt);
            if (act == ACT_HOLD)   hold_cnt   <= sat_inc(hold_cnt);
            if (act == ACT_FLUSH)  flush_cnt  <= sat_inc(flush_cnt);
        end
    end

    // The stall controller only ever stalls a prefix of the pipeline.
    always_ff @(posedge clk) begin
        if (!rst)
            assert (!(!up_stall && dn_stall))
                else $error("pipe_stage_reg: illegal stall vector %b", stall);
    end
`else
    assign bubble_cnt = '0;
    assign hold_cnt   = '0;
    assign flush_cnt  = '0;
`endif

endmodule
